// File: rtl/clock_key_conditioner.sv
// Key front-end for the clock set controls: synchronises, debounces and
// edge-detects the set/up/down buttons, steps the field-select mode and
// issues one-clk active-low up/down strobes with hold-to-auto-repeat.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// MODE_RUN | clock free-running, set_ena=0, field_sel=0, up/down ignored
// MODE_SET | setting field field_q, set_ena=1, field_sel one-hot
module clock_key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000,
    parameter int NUM_FIELDS      = 3,
    parameter int CNT_W           = 25
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  key_set_n,
    input  logic                  key_up_n,
    input  logic                  key_down_n,
    output logic                  set_ena,
    output logic [NUM_FIELDS-1:0] field_sel,
    output logic                  up_n,
    output logic                  down_n
);

    localparam int K_SET   = 0;
    localparam int K_UP    = 1;
    localparam int K_DN    = 2;
    localparam int FIELD_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;

    localparam logic [CNT_W-1:0]   DEB_TC    = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]   RPT_FIRST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0]   RPT_NEXT  = CNT_W'(REPEAT_RATE - 1);
    localparam logic [FIELD_W-1:0] FIELD_LAST = FIELD_W'(NUM_FIELDS - 1);

    typedef enum logic [0:0] {
        MODE_RUN = 1'b0,
        MODE_SET = 1'b1
    } mode_e;

    logic [2:0] key_raw;
    assign key_raw = {key_down_n, key_up_n, key_set_n};

    logic [2:0]       sync1_q, sync1_d;
    logic [2:0]       sync2_q, sync2_d;
    logic [2:0]       stable_q, stable_d;
    logic [2:0]       stable_dly_q, stable_dly_d;
    logic [CNT_W-1:0] deb_cnt_q [3];
    logic [CNT_W-1:0] deb_cnt_d [3];

    mode_e            mode_q, mode_d;
    logic [FIELD_W-1:0] field_q, field_d;

    logic             armed_up_q, armed_up_d;
    logic             armed_dn_q, armed_dn_d;
    logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;

    logic                  set_ena_q, set_ena_d;
    logic [NUM_FIELDS-1:0] field_sel_q, field_sel_d;
    logic                  up_n_q, up_n_d;
    logic                  down_n_q, down_n_d;

    logic [2:0] press;
    logic       in_set;
    logic       accept_up, accept_dn;
    logic       keep_up, keep_dn;
    logic       fire_up, fire_dn;

    // Two-flop synchroniser and per-key debounce: a level change is only
    // accepted once the counter has seen it persist up to its terminal count.
    always_comb begin
        sync1_d      = key_raw;
        sync2_d      = sync1_q;
        stable_dly_d = stable_q;
        stable_d     = stable_q;
        for (int i = 0; i < 3; i++) begin
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (deb_cnt_q[i] >= DEB_TC) begin
                    stable_d[i]  = sync2_q[i];
                    deb_cnt_d[i] = '0;
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Press is a stable 1->0 edge; releases generate nothing.
    assign press = stable_dly_q & ~stable_q;

    // Mode next-state: each set press walks RUN -> field 0 .. last -> RUN.
    always_comb begin
        mode_d  = mode_q;
        field_d = field_q;
        if (press[K_SET]) begin
            if (mode_q == MODE_RUN) begin
                mode_d  = MODE_SET;
                field_d = '0;
            end else if (field_q == FIELD_LAST) begin
                mode_d  = MODE_RUN;
                field_d = '0;
            end else begin
                field_d = field_q + FIELD_W'(1);
            end
        end
        set_ena_d   = (mode_d == MODE_SET);
        field_sel_d = '0;
        for (int k = 0; k < NUM_FIELDS; k++) begin
            field_sel_d[k] = (mode_d == MODE_SET) && (field_d == FIELD_W'(k));
        end
    end

    // Up/down strobes and auto-repeat. A key is "armed" only after an
    // accepted press in set mode; anything that locks it out (set press,
    // other key held, release) disarms it until a fresh press.
    always_comb begin
        in_set    = (mode_q == MODE_SET);
        accept_up = in_set & press[K_UP] & ~press[K_SET] & stable_q[K_DN];
        accept_dn = in_set & press[K_DN] & ~press[K_SET] & stable_q[K_UP];
        keep_up   = armed_up_q & ~stable_q[K_UP] & stable_q[K_DN] & ~press[K_SET];
        keep_dn   = armed_dn_q & ~stable_q[K_DN] & stable_q[K_UP] & ~press[K_SET];
        fire_up   = keep_up & (rpt_cnt_q == '0);
        fire_dn   = keep_dn & (rpt_cnt_q == '0);

        armed_up_d = accept_up | keep_up;
        armed_dn_d = accept_dn | keep_dn;

        rpt_cnt_d = '0;
        if (accept_up | accept_dn) begin
            rpt_cnt_d = RPT_FIRST;
        end else if (fire_up | fire_dn) begin
            rpt_cnt_d = RPT_NEXT;
        end else if ((keep_up | keep_dn) && (rpt_cnt_q != '0)) begin
            rpt_cnt_d = rpt_cnt_q - CNT_W'(1);
        end

        up_n_d   = ~(accept_up | fire_up);
        down_n_d = ~(accept_dn | fire_dn);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q      <= '1;
            sync2_q      <= '1;
            stable_q     <= '1;
            stable_dly_q <= '1;
            for (int i = 0; i < 3; i++) begin
                deb_cnt_q[i] <= '0;
            end
            mode_q       <= MODE_RUN;
            field_q      <= '0;
            armed_up_q   <= 1'b0;
            armed_dn_q   <= 1'b0;
            rpt_cnt_q    <= '0;
            set_ena_q    <= 1'b0;
            field_sel_q  <= '0;
            up_n_q       <= 1'b1;
            down_n_q     <= 1'b1;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            for (int i = 0; i < 3; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
            mode_q       <= mode_d;
            field_q      <= field_d;
            armed_up_q   <= armed_up_d;
            armed_dn_q   <= armed_dn_d;
            rpt_cnt_q    <= rpt_cnt_d;
            set_ena_q    <= set_ena_d;
            field_sel_q  <= field_sel_d;
            up_n_q       <= up_n_d;
            down_n_q     <= down_n_d;
        end
    end

    assign set_ena   = set_ena_q;
    assign field_sel = field_sel_q;
    assign up_n      = up_n_q;
    assign down_n    = down_n_q;

endmodule

// File: tb/tb_clock_key_conditioner.sv
// Bench for clock_key_conditioner with small timing parameters. A
// behavioural model (sample-history debounce, cycles-since-strobe repeat)
// is compared against the DUT every cycle; directed tests add literal
// timing expectations.
module tb_clock_key_conditioner;

    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RR = 8;
    localparam int NF = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          key_set_n, key_up_n, key_down_n;
    logic          set_ena;
    logic [NF-1:0] field_sel;
    logic          up_n, down_n;

    clock_key_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR),
        .NUM_FIELDS     (NF),
        .CNT_W          (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_set_n (key_set_n),
        .key_up_n  (key_up_n),
        .key_down_n(key_down_n),
        .set_ena   (set_ena),
        .field_sel (field_sel),
        .up_n      (up_n),
        .down_n    (down_n)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    int up_log[$];
    int dn_log[$];
    int fs_cyc[$];
    int fs_val[$];
    int prev_fs = 0;

    // model state: index 0=set, 1=up, 2=down
    logic [15:0] m_hist [3];
    bit          m_st   [3];
    bit          m_pr   [3];
    bit          m_arm  [3];
    int          m_since[3];
    bit          m_first[3];
    int          m_field = -1;
    bit          m_up = 1'b1;
    bit          m_dn = 1'b1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step(input bit rst, input bit raw [3]);
        bit all_diff;
        bit new_st;
        int o;
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                m_hist[i]  = '1;
                m_st[i]    = 1'b1;
                m_pr[i]    = 1'b0;
                m_arm[i]   = 1'b0;
                m_since[i] = 0;
                m_first[i] = 1'b0;
            end
            m_field = -1;
            m_up    = 1'b1;
            m_dn    = 1'b1;
        end else begin
            m_up = 1'b1;
            m_dn = 1'b1;
            if (m_pr[0]) begin
                m_field  = (m_field == NF - 1) ? -1 : m_field + 1;
                m_arm[1] = 1'b0;
                m_arm[2] = 1'b0;
            end else begin
                for (int k = 1; k <= 2; k++) begin
                    o = 3 - k;
                    if (m_pr[k] && m_field >= 0 && !m_pr[o] && m_st[o]) begin
                        if (k == 1) m_up = 1'b0; else m_dn = 1'b0;
                        m_arm[k]   = 1'b1;
                        m_since[k] = 0;
                        m_first[k] = 1'b1;
                    end else if (m_arm[k] && !m_st[k] && m_st[o]) begin
                        m_since[k]++;
                        if (m_since[k] == (m_first[k] ? RD : RR)) begin
                            if (k == 1) m_up = 1'b0; else m_dn = 1'b0;
                            m_since[k] = 0;
                            m_first[k] = 1'b0;
                        end
                    end else begin
                        m_arm[k] = 1'b0;
                    end
                end
            end
            // new level accepted once D+1 consecutive samples, seen through
            // the 2-cycle synchroniser, all disagree with the current level
            for (int i = 0; i < 3; i++) begin
                m_hist[i] = {m_hist[i][14:0], raw[i]};
                all_diff  = 1'b1;
                for (int j = 2; j <= D + 2; j++) begin
                    if (m_hist[i][j] == m_st[i]) all_diff = 1'b0;
                end
                new_st  = all_diff ? ~m_st[i] : m_st[i];
                m_pr[i] = m_st[i] && !new_st;
                m_st[i] = new_st;
            end
        end
    endtask

    // Per-cycle compare against the model, plus event logging.
    initial begin
        bit raw [3];
        int exp_v, act_v, fs_now;
        forever begin
            @(negedge clk);
            cyc++;
            raw[0] = key_set_n;
            raw[1] = key_up_n;
            raw[2] = key_down_n;
            model_step(rst_n, raw);
            exp_v = 0;
            for (int k = 0; k < NF; k++) begin
                if (m_field == k) exp_v = exp_v | (1 << (k + 2));
            end
            if (m_field >= 0) exp_v = exp_v | (1 << (NF + 2));
            exp_v = exp_v | (int'(m_up) << 1) | int'(m_dn);
            act_v = int'({set_ena, field_sel, up_n, down_n});
            check("outputs_vs_model", act_v, exp_v);
            if (!up_n) up_log.push_back(cyc);
            if (!down_n) dn_log.push_back(cyc);
            fs_now = int'({set_ena, field_sel});
            if (fs_now != prev_fs) begin
                fs_cyc.push_back(cyc);
                fs_val.push_back(fs_now);
                prev_fs = fs_now;
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic press_set();
        key_set_n = 1'b0;
        wait_cyc(10);
        key_set_n = 1'b1;
        wait_cyc(10);
    endtask

    initial begin
        int e, r, n0, nd;
        int exp_fs [4];
        int offs [6];
        exp_fs = '{4'b1001, 4'b1010, 4'b1100, 4'b0000};
        offs   = '{0, 20, 28, 36, 44, 52};
        rst_n = 1'b0;
        key_set_n = 1'b1;
        key_up_n = 1'b1;
        key_down_n = 1'b1;

        // 1: reset and idle
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(50);
        check("idle_fs_changes", fs_cyc.size(), 0);
        check("idle_up_strobes", up_log.size(), 0);
        check("idle_dn_strobes", dn_log.size(), 0);

        // 2: mode cycling
        for (int p = 0; p < 4; p++) begin
            e = cyc + 1;
            press_set();
            check("mode_change_count", fs_cyc.size(), p + 1);
            if (fs_cyc.size() > p) begin
                check("mode_change_time", fs_cyc[p], e + 7);
                check("mode_change_value", fs_val[p], exp_fs[p]);
            end
        end

        // 3: bounce rejection in field 0
        press_set();
        n0 = up_log.size();
        key_up_n = 1'b0; wait_cyc(3);
        key_up_n = 1'b1; wait_cyc(1);
        key_up_n = 1'b0; wait_cyc(2);
        key_up_n = 1'b1; wait_cyc(10);
        check("bounce_no_strobe", up_log.size() - n0, 0);
        e = cyc + 1;
        key_up_n = 1'b0; wait_cyc(10);
        key_up_n = 1'b1; wait_cyc(20);
        check("clean_press_count", up_log.size() - n0, 1);
        if (up_log.size() > n0) check("clean_press_latency", up_log[n0], e + 7);

        // 4: auto-repeat in field 1
        press_set();
        n0 = dn_log.size();
        e = cyc + 1;
        key_down_n = 1'b0; wait_cyc(60);
        key_down_n = 1'b1; wait_cyc(40);
        check("repeat_count", dn_log.size() - n0, 6);
        if (dn_log.size() >= n0 + 6) begin
            check("repeat_first_latency", dn_log[n0], e + 7);
            for (int i = 1; i < 6; i++) begin
                check("repeat_offset", dn_log[n0 + i] - dn_log[n0], offs[i]);
            end
        end

        // 5: conflicts in field 2
        press_set();
        n0 = up_log.size();
        nd = dn_log.size();
        key_up_n = 1'b0; wait_cyc(16);
        key_down_n = 1'b0; wait_cyc(10);
        key_down_n = 1'b1; wait_cyc(40);
        check("conflict_up_count", up_log.size() - n0, 1);
        check("conflict_dn_count", dn_log.size() - nd, 0);
        press_set();
        check("held_set_to_run", fs_val[fs_val.size() - 1], 0);
        key_up_n = 1'b1; wait_cyc(20);
        check("locked_up_count", up_log.size() - n0, 1);
        check("locked_dn_count", dn_log.size() - nd, 0);

        // 6: reset while repeating in field 0
        press_set();
        n0 = up_log.size();
        key_up_n = 1'b0; wait_cyc(32);
        check("pre_reset_strobes", up_log.size() - n0, 2);
        r = cyc + 1;
        rst_n = 1'b0; wait_cyc(1);
        rst_n = 1'b1; wait_cyc(30);
        key_up_n = 1'b1; wait_cyc(20);
        check("post_reset_strobes", up_log.size() - n0, 2);
        check("reset_fs_time", fs_cyc[fs_cyc.size() - 1], r);
        check("reset_fs_value", fs_val[fs_val.size() - 1], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
